zone_color_detector: RTL and testbench

ZONE_COLOR_DETECTOR -- requirements
Module: zone_color_detector

---
 rtl/zone_det_pkg.sv | 38 +++
 rtl/zone_accum.sv | 80 ++++++++
 rtl/zone_color_detector.sv | 150 +++++++++++++++
 tb/tb_zone_color_detector.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/zone_det_pkg.sv
// Shared types and elaboration helpers for the zone colour detector:
// RGB565 field widths, threshold bundle, and zone-centre geometry.
package zone_det_pkg;

  localparam int R_W = 5;
  localparam int G_W = 6;
  localparam int B_W = 5;

  typedef struct packed {
    logic [R_W-1:0] r_min;
    logic [G_W-1:0] g_max;
    logic [B_W-1:0] b_max;
    logic [R_W-1:0] r_minus_g;
    logic [R_W-1:0] r_minus_b;
  } thr_t;

  localparam thr_t THR_RST = '{r_min: 5'd12, g_max: 6'd36, b_max: 5'd14,
                               r_minus_g: 5'd6, r_minus_b: 5'd6};

  function automatic int zone_centre(input int idx, input int nzones, input int size);
    return ((2 * idx + 1) * size) / (2 * nzones);
  endfunction

  // Windows along one axis must be odd-sized, inside the frame and disjoint.
  function automatic bit windows_ok(input int nzones, input int size, input int win);
    int half;
    int c;
    half = win / 2;
    if (win < 1 || (win % 2) == 0) return 1'b0;
    for (int i = 0; i < nzones; i++) begin
      c = zone_centre(i, nzones, size);
      if (c - half < 0 || c + half > size - 1) return 1'b0;
      if (i > 0 && c - zone_centre(i - 1, nzones, size) < win) return 1'b0;
    end
    return 1'b1;
  endfunction

endpackage

// File: rtl/zone_accum.sv
// One zone's colour sums, sample counter and threshold test.
// pending_o is registered one cycle after the N-th sample lands.
module zone_accum
  import zone_det_pkg::*;
#(
  parameter int N = 25
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clr_i,
  input  logic           acc_i,
  input  logic [R_W-1:0] r_i,
  input  logic [G_W-1:0] g_i,
  input  logic [B_W-1:0] b_i,
  input  thr_t           thr_i,
  output logic           pending_o
);
  localparam int SRW = $clog2(31 * N + 1);
  localparam int SGW = $clog2(63 * N + 1);
  localparam int CW  = $clog2(N + 1);
  localparam int EW  = SGW + 2;
  localparam logic signed [EW-1:0] NS = EW'(N);

  logic [SRW-1:0] sum_r_q, sum_r_d, sum_b_q, sum_b_d;
  logic [SGW-1:0] sum_g_q, sum_g_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           pending_q, full, pass;
  logic signed [EW-1:0] sr, sg, sb, lim_r, lim_g, lim_b, lim_rg, lim_rb;

  assign full = (cnt_q == CW'(N));

  always_comb begin
    sum_r_d = sum_r_q;
    sum_g_d = sum_g_q;
    sum_b_d = sum_b_q;
    cnt_d   = cnt_q;
    if (clr_i) begin
      sum_r_d = '0;
      sum_g_d = '0;
      sum_b_d = '0;
      cnt_d   = '0;
    end else if (acc_i && !full) begin
      sum_r_d = sum_r_q + SRW'(r_i);
      sum_g_d = sum_g_q + SGW'(g_i);
      sum_b_d = sum_b_q + SRW'(b_i);
      cnt_d   = cnt_q + CW'(1);
    end
  end

  // Signed compare so a negative colour difference fails the test.
  assign sr     = $signed(EW'(sum_r_q));
  assign sg     = $signed(EW'(sum_g_q));
  assign sb     = $signed(EW'(sum_b_q));
  assign lim_r  = NS * $signed(EW'(thr_i.r_min));
  assign lim_g  = NS * $signed(EW'(thr_i.g_max));
  assign lim_b  = NS * $signed(EW'(thr_i.b_max));
  assign lim_rg = NS * $signed(EW'(thr_i.r_minus_g));
  assign lim_rb = NS * $signed(EW'(thr_i.r_minus_b));
  assign pass   = (sr >= lim_r) && (sg <= lim_g) && (sb <= lim_b) &&
                  ((sr - (sg >>> 1)) >= lim_rg) && ((sr - sb) >= lim_rb);

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_r_q   <= '0;
      sum_g_q   <= '0;
      sum_b_q   <= '0;
      cnt_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      sum_r_q   <= sum_r_d;
      sum_g_q   <= sum_g_d;
      sum_b_q   <= sum_b_d;
      cnt_q     <= cnt_d;
      pending_q <= !clr_i && full && pass;
    end
  end

  assign pending_o = pending_q;

endmodule

// File: rtl/zone_color_detector.sv
// Per-zone colour detector over a raster RGB565 stream; reports a zone hit
// vector and its popcount three cycles after the last pixel of each frame.
module zone_color_detector
  import zone_det_pkg::*;
#(
  parameter  int W   = 320,
  parameter  int H   = 240,
  parameter  int NX  = 3,
  parameter  int NY  = 3,
  parameter  int WIN = 5,
  localparam int NZ  = NX * NY,
  localparam int HCW = $clog2(NZ + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           frame_start,
  input  logic           pix_valid,
  input  logic [15:0]    pix_data,
  input  logic [R_W-1:0] r_min,
  input  logic [G_W-1:0] g_max,
  input  logic [B_W-1:0] b_max,
  input  logic [R_W-1:0] r_minus_g,
  input  logic [R_W-1:0] r_minus_b,
  output logic [NZ-1:0]  zone_hit,
  output logic [HCW-1:0] hit_count,
  output logic           result_valid,
  output logic           frame_abort
);
  localparam int N    = WIN * WIN;
  localparam int HALF = WIN / 2;
  localparam int XW   = (W > 1) ? $clog2(W) : 1;
  localparam int YW   = (H > 1) ? $clog2(H) : 1;

  if (NZ > 16 || !windows_ok(NX, W, WIN) || !windows_ok(NY, H, WIN)) begin : g_param_err
    $error("zone_color_detector: illegal zone geometry");
  end

  logic [XW-1:0]  x_q, x_d, x_cur;
  logic [YW-1:0]  y_q, y_d, y_cur;
  logic           active_q, active_d, busy_q, accept, is_last, comp;
  logic [2:0]     lst_pipe_q;
  thr_t           thr_q;
  logic           s1_vld_q;
  logic [R_W-1:0] s1_r_q;
  logic [G_W-1:0] s1_g_q;
  logic [B_W-1:0] s1_b_q;
  logic [NZ-1:0]  s1_zone_q, zone_d, pend, zone_hit_q;
  logic [HCW-1:0] pop, hit_count_q;
  logic           result_valid_q, frame_abort_q;

  // A pixel arriving with frame_start is pixel (0,0) of the new frame.
  assign x_cur   = frame_start ? '0 : x_q;
  assign y_cur   = frame_start ? '0 : y_q;
  assign accept  = pix_valid && (frame_start || active_q);
  assign is_last = (x_cur == XW'(W - 1)) && (y_cur == YW'(H - 1));
  assign comp    = lst_pipe_q[2];

  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    active_d = active_q;
    if (frame_start) begin
      x_d      = '0;
      y_d      = '0;
      active_d = 1'b1;
    end
    if (accept) begin
      if (x_cur == XW'(W - 1)) begin
        x_d = '0;
        y_d = y_cur + YW'(1);
      end else begin
        x_d = x_cur + XW'(1);
      end
      if (is_last) active_d = 1'b0;
    end
  end

  for (genvar z = 0; z < NZ; z++) begin : g_zone
    localparam int CX = zone_centre(z % NX, NX, W);
    localparam int CY = zone_centre(z / NX, NY, H);
    assign zone_d[z] = (x_cur >= XW'(CX - HALF)) && (x_cur <= XW'(CX + HALF)) &&
                       (y_cur >= YW'(CY - HALF)) && (y_cur <= YW'(CY + HALF));
    zone_accum #(.N(N)) u_acc (
      .clk      (clk),
      .reset    (reset),
      .clr_i    (frame_start),
      .acc_i    (s1_vld_q && s1_zone_q[z]),
      .r_i      (s1_r_q),
      .g_i      (s1_g_q),
      .b_i      (s1_b_q),
      .thr_i    (thr_q),
      .pending_o(pend[z])
    );
  end

  always_comb begin
    pop = '0;
    for (int k = 0; k < NZ; k++) pop = pop + HCW'(pend[k]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q            <= '0;
      y_q            <= '0;
      active_q       <= 1'b0;
      busy_q         <= 1'b0;
      lst_pipe_q     <= '0;
      thr_q          <= THR_RST;
      s1_vld_q       <= 1'b0;
      s1_r_q         <= '0;
      s1_g_q         <= '0;
      s1_b_q         <= '0;
      s1_zone_q      <= '0;
      zone_hit_q     <= '0;
      hit_count_q    <= '0;
      result_valid_q <= 1'b0;
      frame_abort_q  <= 1'b0;
    end else begin
      x_q            <= x_d;
      y_q            <= y_d;
      active_q       <= active_d;
      busy_q         <= frame_start ? 1'b1 : (comp ? 1'b0 : busy_q);
      s1_vld_q       <= accept;
      s1_r_q         <= pix_data[15:11];
      s1_g_q         <= pix_data[10:5];
      s1_b_q         <= pix_data[4:0];
      s1_zone_q      <= zone_d;
      frame_abort_q  <= frame_start && busy_q;
      result_valid_q <= comp && !frame_start;
      // A restart drops any completion still in flight from the old frame.
      if (frame_start) begin
        lst_pipe_q <= {2'b00, accept && is_last};
        thr_q      <= '{r_min: r_min, g_max: g_max, b_max: b_max,
                        r_minus_g: r_minus_g, r_minus_b: r_minus_b};
      end else begin
        lst_pipe_q <= {lst_pipe_q[1:0], accept && is_last};
      end
      if (comp && !frame_start) begin
        zone_hit_q  <= pend;
        hit_count_q <= pop;
      end
    end
  end

  assign zone_hit     = zone_hit_q;
  assign hit_count    = hit_count_q;
  assign result_valid = result_valid_q;
  assign frame_abort  = frame_abort_q;

endmodule

// File: tb/tb_zone_color_detector.sv
// Directed + randomized frames on a 64x32, 4x2-zone, 3x3-window detector,
// checked against a frame-buffer reference model.
module tb_zone_color_detector;
  localparam int W = 64, H = 32, NX = 4, NY = 2, WIN = 3;
  localparam int NZ = NX * NY, N = WIN * WIN, HALF = WIN / 2, HCW = $clog2(NZ + 1);

  logic clk = 1'b0;
  logic reset, frame_start, pix_valid;
  logic [15:0] pix_data;
  logic [4:0] r_min, b_max, r_minus_g, r_minus_b;
  logic [5:0] g_max;
  logic [NZ-1:0] zone_hit;
  logic [HCW-1:0] hit_count;
  logic result_valid, frame_abort;

  int compared = 0, mismatched = 0;
  int rv_cnt = 0, ab_cnt = 0;
  logic [15:0] fr [H][W];
  int t_rmin, t_gmax, t_bmax, t_rmg, t_rmb;

  zone_color_detector #(.W(W), .H(H), .NX(NX), .NY(NY), .WIN(WIN)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .pix_valid(pix_valid),
    .pix_data(pix_data), .r_min(r_min), .g_max(g_max), .b_max(b_max),
    .r_minus_g(r_minus_g), .r_minus_b(r_minus_b), .zone_hit(zone_hit),
    .hit_count(hit_count), .result_valid(result_valid), .frame_abort(frame_abort)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    rv_cnt += int'(result_valid);
    ab_cnt += int'(frame_abort);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int zc(input int i, input int n, input int s);
    return ((2 * i + 1) * s) / (2 * n);
  endfunction

  function automatic logic [15:0] mk(input int r, input int g, input int b);
    logic [4:0] r5;
    logic [5:0] g6;
    logic [4:0] b5;
    r5 = 5'(r); g6 = 6'(g); b5 = 5'(b);
    return {r5, g6, b5};
  endfunction

  // Reference: sum every pixel inside each zone window and apply the rules.
  function automatic logic [NZ-1:0] model();
    logic [NZ-1:0] h;
    h = '0;
    for (int z = 0; z < NZ; z++) begin
      int cx, cy, sr, sg, sb, cnt;
      cx = zc(z % NX, NX, W); cy = zc(z / NX, NY, H);
      sr = 0; sg = 0; sb = 0; cnt = 0;
      for (int y = 0; y < H; y++)
        for (int x = 0; x < W; x++)
          if (x - cx <= HALF && cx - x <= HALF && y - cy <= HALF && cy - y <= HALF) begin
            sr += int'(fr[y][x][15:11]);
            sg += int'(fr[y][x][10:5]);
            sb += int'(fr[y][x][4:0]);
            cnt++;
          end
      h[z] = (cnt == N) && (sr >= N * t_rmin) && (sg <= N * t_gmax) && (sb <= N * t_bmax) &&
             (sr - sg / 2 >= N * t_rmg) && (sr - sb >= N * t_rmb);
    end
    return h;
  endfunction

  task automatic set_thr(input int a, input int b, input int c, input int d, input int e);
    t_rmin = a; t_gmax = b; t_bmax = c; t_rmg = d; t_rmb = e;
  endtask

  task automatic paint(input int z, input logic [15:0] p);
    int cx, cy;
    cx = zc(z % NX, NX, W); cy = zc(z / NX, NY, H);
    for (int dy = -HALF; dy <= HALF; dy++)
      for (int dx = -HALF; dx <= HALF; dx++) fr[cy + dy][cx + dx] = p;
  endtask

  // 0 red, 1 green, 2 red zone5/grey, 3 boundary hit, 4 boundary minus one,
  // 5 R12/G36/B6 windows on defaults, 6 random
  task automatic fill_frame(input int mode);
    logic [15:0] bg;
    bg = (mode == 0) ? 16'hF800 : (mode == 1) ? 16'h07E0 : 16'h8410;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) fr[y][x] = (mode == 6) ? 16'($urandom) : bg;
    set_thr(12, 36, 14, 6, 6);
    if (mode == 2) paint(5, 16'hF800);
    if (mode == 3 || mode == 4) begin
      set_thr(20, 28, 6, 6, 14);
      for (int z = 0; z < NZ; z++) paint(z, mk(20, 28, 6));
      if (mode == 4) fr[zc(0, NY, H)][zc(2, NX, W)] = mk(19, 28, 6);
    end
    if (mode == 5) for (int z = 0; z < NZ; z++) paint(z, mk(12, 36, 6));
    if (mode == 6) begin
      set_thr($urandom_range(8, 20), $urandom_range(16, 50), $urandom_range(6, 20),
              $urandom_range(0, 12), $urandom_range(0, 14));
      for (int z = 0; z < NZ; z++) begin
        int br, bgr, bb, cx, cy;
        br = $urandom_range(16, 31); bgr = $urandom_range(0, 24); bb = $urandom_range(0, 10);
        cx = zc(z % NX, NX, W); cy = zc(z / NX, NY, H);
        if ($urandom_range(0, 3) != 0)
          for (int dy = -HALF; dy <= HALF; dy++)
            for (int dx = -HALF; dx <= HALF; dx++)
              fr[cy + dy][cx + dx] = mk(br - $urandom_range(0, 3), bgr + $urandom_range(0, 3),
                                        bb + $urandom_range(0, 2));
      end
    end
  endtask

  task automatic drive_thr();
    r_min = 5'(t_rmin); g_max = 6'(t_gmax); b_max = 5'(t_bmax);
    r_minus_g = 5'(t_rmg); r_minus_b = 5'(t_rmb);
  endtask

  task automatic partial(input int n);
    frame_start = 1'b1; pix_valid = 1'b0; tick(); frame_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      pix_valid = 1'b1; pix_data = 16'($urandom); tick();
    end
    pix_valid = 1'b0;
  endtask

  task automatic run_frame(input int mode, input bit coincide, input bit expect_abort,
                           output logic [NZ-1:0] exp_hit);
    int idx, k, rv0, ab0;
    bit found;
    logic [NZ-1:0] prev;
    fill_frame(mode);
    exp_hit = model();
    prev = zone_hit; rv0 = rv_cnt; ab0 = ab_cnt;
    drive_thr();
    frame_start = 1'b1; idx = 0;
    if (coincide) begin pix_valid = 1'b1; pix_data = fr[0][0]; idx = 1; end
    else pix_valid = 1'b0;
    tick();
    frame_start = 1'b0;
    // shadowed thresholds: these must not influence the running frame
    r_min = 5'($urandom); g_max = 6'($urandom); b_max = 5'($urandom);
    r_minus_g = 5'($urandom); r_minus_b = 5'($urandom);
    chk("frame_abort", 32'(frame_abort), 32'(expect_abort));
    chk("hit_held_start", 32'(zone_hit), 32'(prev));
    while (idx < W * H) begin
      pix_valid = ($urandom_range(0, 3) != 0);
      pix_data = pix_valid ? fr[idx / W][idx % W] : 16'($urandom);
      tick();
      if (pix_valid) idx++;
    end
    chk("hit_held_end", 32'(zone_hit), 32'(prev));
    k = 0; found = 1'b0;
    while (!found && k < 20) begin
      pix_valid = 1'($urandom_range(0, 1)); pix_data = 16'hF800;
      tick(); k++;
      if (result_valid) found = 1'b1;
    end
    pix_valid = 1'b0;
    chk("latency", 32'(k), 32'd3);
    chk("zone_hit", 32'(zone_hit), 32'(exp_hit));
    chk("hit_count", 32'(hit_count), 32'($countones(exp_hit)));
    tick();
    chk("rv_one_cycle", 32'(result_valid), 32'd0);
    chk("rv_pulses", 32'(rv_cnt - rv0), 32'd1);
    chk("abort_pulses", 32'(ab_cnt - ab0), 32'(expect_abort));
  endtask

  initial begin
    logic [NZ-1:0] e;
    int rv0;
    reset = 1'b1; frame_start = 1'b0; pix_valid = 1'b0; pix_data = '0;
    set_thr(12, 36, 14, 6, 6); drive_thr();
    repeat (3) tick();
    chk("rst_zone_hit", 32'(zone_hit), 32'd0);
    chk("rst_hit_count", 32'(hit_count), 32'd0);
    chk("rst_result_valid", 32'(result_valid), 32'd0);
    chk("rst_frame_abort", 32'(frame_abort), 32'd0);
    reset = 1'b0;

    run_frame(0, 1'b0, 1'b0, e); chk("red_all", 32'(zone_hit), 32'hFF);
    run_frame(1, 1'b1, 1'b0, e); chk("green_none", 32'(zone_hit), 32'h00);
    run_frame(2, 1'b0, 1'b0, e); chk("red_zone5", 32'(zone_hit), 32'h20);
    run_frame(3, 1'b1, 1'b0, e); chk("thr_equal", 32'(zone_hit), 32'hFF);
    run_frame(4, 1'b0, 1'b0, e); chk("thr_minus1", 32'(zone_hit), 32'hFB);
    run_frame(5, 1'b0, 1'b0, e);

    // abort a partial frame, then the restarting frame reports normally
    run_frame(0, 1'b0, 1'b0, e);
    rv0 = rv_cnt;
    partial(1000);
    chk("no_rv_partial", 32'(rv_cnt - rv0), 32'd0);
    run_frame(2, 1'b1, 1'b1, e); chk("after_abort", 32'(zone_hit), 32'h20);

    for (int f = 0; f < 6; f++) run_frame(6, 1'($urandom_range(0, 1)), 1'b0, e);

    // reset mid-frame, then pixels without frame_start must be ignored
    run_frame(0, 1'b0, 1'b0, e);
    partial(700);
    reset = 1'b1; pix_valid = 1'b1; tick(); tick();
    chk("mid_rst_zone_hit", 32'(zone_hit), 32'd0);
    chk("mid_rst_hit_count", 32'(hit_count), 32'd0);
    chk("mid_rst_result_valid", 32'(result_valid), 32'd0);
    chk("mid_rst_frame_abort", 32'(frame_abort), 32'd0);
    reset = 1'b0; rv0 = rv_cnt;
    for (int i = 0; i < W * H + 20; i++) begin
      pix_valid = 1'b1; pix_data = 16'hF800; tick();
    end
    pix_valid = 1'b0;
    repeat (6) tick();
    chk("ignored_no_rv", 32'(rv_cnt - rv0), 32'd0);
    chk("ignored_hit", 32'(zone_hit), 32'd0);
    run_frame(6, 1'b0, 1'b0, e);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
